surv_buf_pp: RTL and testbench

SURV_BUF_PP -- requirements
Module: surv_buf_pp

---
 rtl/viterbi_pkg.sv | 15 +
 rtl/sram_1r1w.sv | 28 ++
 rtl/surv_buf_pp.sv | 119 +++++++++++
 tb/tb_surv_buf_pp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the Viterbi survivor-path buffer.
package viterbi_pkg;
   localparam int DATA_W_DEF = 64;
   localparam int ADDR_W_DEF = 6;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } bank_state_e;

   function automatic logic [1:0] full_count(input bank_state_e s0, input bank_state_e s1);
      return {1'b0, s0 == FULL} + {1'b0, s1 == FULL};
   endfunction
endpackage

// File: rtl/sram_1r1w.sv
// One-write/one-read bank with a registered read port; array contents are never reset.
module sram_1r1w #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the read register is cleared so the top's held output returns to zero on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   rdata <= '0;
      else if (clr) rdata <= '0;
      else if (re)  rdata <= mem[raddr];
   end
endmodule

// File: rtl/surv_buf_pp.sv
// Ping-pong survivor-path buffer: ACS writes one bank while traceback reads the other.
// Define SURV_BUF_PARITY_EN to store an even-parity bit per word and flag read mismatches.
module surv_buf_pp
   import viterbi_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_an_i,
   input  logic              rst_sync_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_done_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              rd_done_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   output logic              wr_ready_o,
   output logic              rd_ready_o,
   output logic [1:0]        full_cnt_o,
   output logic              err_o,
   output logic              rd_perr_o
);
`ifdef SURV_BUF_PARITY_EN
   localparam int PW = 1;
`else
   localparam int PW = 0;
`endif
   localparam int MEM_W = DATA_W + PW;

   bank_state_e state_q [2];
   bank_state_e state_d [2];
   logic        wbank_q, rbank_q, rsel_q, rd_valid_q, err_q;
   logic        wr_acc, wd_acc, rd_acc, rdd_acc, viol;
   logic [MEM_W-1:0]            mem_wdata;
   logic [1:0][MEM_W-1:0]       q;

   assign wr_ready_o = (state_q[wbank_q] != FULL);
   assign rd_ready_o = (state_q[rbank_q] == FULL);

   // Synchronous clear swallows every strobe in its cycle.
   assign wr_acc  = wr_en_i   & wr_ready_o & ~rst_sync_i;
   assign wd_acc  = wr_done_i & wr_ready_o & ~rst_sync_i;
   assign rd_acc  = rd_en_i   & rd_ready_o & ~rst_sync_i;
   assign rdd_acc = rd_done_i & rd_ready_o & ~rst_sync_i;
   assign viol    = ((wr_en_i | wr_done_i) & ~wr_ready_o) | ((rd_en_i | rd_done_i) & ~rd_ready_o);

   // wbank and rbank can only name the same bank if it is FULL (read side) or not (write side),
   // so the write and read updates below never target one bank in the same cycle.
   always_comb begin
      for (int b = 0; b < 2; b++) state_d[b] = state_q[b];
      if (wr_acc && state_q[wbank_q] == FREE) state_d[wbank_q] = FILL;
      if (wd_acc)  state_d[wbank_q] = FULL;
      if (rdd_acc) state_d[rbank_q] = FREE;
   end

   always_ff @(posedge clk_i or negedge rst_an_i) begin
      if (!rst_an_i) begin
         state_q[0] <= FREE;
         state_q[1] <= FREE;
         wbank_q    <= 1'b0;
         rbank_q    <= 1'b0;
         rsel_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else if (rst_sync_i) begin
         state_q[0] <= FREE;
         state_q[1] <= FREE;
         wbank_q    <= 1'b0;
         rbank_q    <= 1'b0;
         rsel_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q[0] <= state_d[0];
         state_q[1] <= state_d[1];
         if (wd_acc)  wbank_q <= ~wbank_q;
         if (rdd_acc) rbank_q <= ~rbank_q;
         if (rd_acc)  rsel_q  <= rbank_q;
         rd_valid_q <= rd_acc;
         if (viol)    err_q   <= 1'b1;
      end
   end

`ifdef SURV_BUF_PARITY_EN
   assign mem_wdata = {^wr_data_i, wr_data_i};
`else
   assign mem_wdata = wr_data_i;
`endif

   for (genvar b = 0; b < 2; b++) begin : g_bank
      sram_1r1w #(.DATA_W(MEM_W), .ADDR_W(ADDR_W)) u_sram (
         .clk   (clk_i),
         .rst_n (rst_an_i),
         .clr   (rst_sync_i),
         .we    (wr_acc && wbank_q == 1'(b)),
         .waddr (wr_addr_i),
         .wdata (mem_wdata),
         .re    (rd_acc && rbank_q == 1'(b)),
         .raddr (rd_addr_i),
         .rdata (q[b])
      );
   end

   // Each bank's read register holds its last word, so muxing by the last-read bank holds the output.
   assign rd_data_o  = q[rsel_q][DATA_W-1:0];
   assign rd_valid_o = rd_valid_q;
   assign full_cnt_o = full_count(state_q[0], state_q[1]);
   assign err_o      = err_q;

`ifdef SURV_BUF_PARITY_EN
   assign rd_perr_o = rd_valid_q & (^q[rsel_q]);
`else
   assign rd_perr_o = 1'b0;
`endif
endmodule

// File: tb/tb_surv_buf_pp.sv
// Directed self-checking bench for surv_buf_pp; parity test runs when SURV_BUF_PARITY_EN is defined.
module tb_surv_buf_pp;
   localparam int DW = 64;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_an, rst_sync;
   logic          wr_en, wr_done, rd_en, rd_done;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data, rd_data;
   logic          rd_valid, wr_ready, rd_ready, err, rd_perr;
   logic [1:0]    full_cnt;
   int            n_tests = 0;
   int            n_fail  = 0;

   surv_buf_pp #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk_i(clk), .rst_an_i(rst_an), .rst_sync_i(rst_sync),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_done_i(wr_done),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_done_i(rd_done),
      .rd_data_o(rd_data), .rd_valid_o(rd_valid), .wr_ready_o(wr_ready), .rd_ready_o(rd_ready),
      .full_cnt_o(full_cnt), .err_o(err), .rd_perr_o(rd_perr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0; rst_sync = 0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_data"},  rd_data, 64'h0);
      chk({tag, "_valid"}, rd_valid, 1'b0);
      chk({tag, "_wrdy"},  wr_ready, 1'b1);
      chk({tag, "_rrdy"},  rd_ready, 1'b0);
      chk({tag, "_cnt"},   full_cnt, 2'd0);
      chk({tag, "_err"},   err, 1'b0);
      chk({tag, "_perr"},  rd_perr, 1'b0);
   endtask

   initial begin
      idle();
      rst_an = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
      #12;
      chk_reset_outs("por");
      rst_an = 1;
      step();

      // Fill bank0 with addr*0x0101 and close it
      for (int a = 0; a < 64; a++) begin
         wr_en = 1; wr_addr = AW'(a); wr_data = 64'(a) * 64'h0101;
         step();
      end
      wr_en = 0; wr_done = 1;
      step();
      wr_done = 0;
      chk("fill0_cnt", full_cnt, 2'd1);
      chk("fill0_rrdy", rd_ready, 1'b1);
      chk("fill0_wrdy", wr_ready, 1'b1);
      chk("fill0_err", err, 1'b0);

      // Read back high to low, one-cycle latency
      for (int a = 63; a >= 0; a--) begin
         rd_en = 1; rd_addr = AW'(a);
         step();
         chk("rd0_valid", rd_valid, 1'b1);
         chk("rd0_data", rd_data, 64'(a) * 64'h0101);
         chk("rd0_perr", rd_perr, 1'b0);
      end
      rd_addr = 6'd5;
      step();
      rd_en = 0;
      step();
      chk("hold_valid", rd_valid, 1'b0);
      chk("hold_data", rd_data, 64'h0505);

      // Fill bank1, then an extra write must be refused
      for (int a = 0; a < 64; a++) begin
         wr_en = 1; wr_addr = AW'(a); wr_data = 64'hA5A5_0000_0000_0000 | 64'(a);
         step();
      end
      wr_en = 0; wr_done = 1;
      step();
      wr_done = 0;
      chk("full2_cnt", full_cnt, 2'd2);
      chk("full2_wrdy", wr_ready, 1'b0);
      chk("full2_err0", err, 1'b0);
      wr_en = 1; wr_addr = 6'd3; wr_data = 64'hDEAD;
      step();
      wr_en = 0;
      chk("ovf_err", err, 1'b1);
      chk("ovf_cnt", full_cnt, 2'd2);
      rd_en = 1; rd_addr = 6'd3;
      step();
      chk("ovf_nowrite", rd_data, 64'h0303);

      // Release bank0 with a same-cycle read
      rd_addr = 6'd7; rd_done = 1;
      step();
      rd_done = 0;
      chk("rdd_valid", rd_valid, 1'b1);
      chk("rdd_data", rd_data, 64'h0707);
      chk("rdd_cnt", full_cnt, 2'd1);
      chk("rdd_wrdy", wr_ready, 1'b1);
      chk("rdd_rrdy", rd_ready, 1'b1);
      rd_addr = 6'd8;
      step();
      rd_en = 0;
      chk("rd1_data", rd_data, 64'hA5A5_0000_0000_0008);

      // Simultaneous wr_done (bank0) and rd_done (bank1)
      wr_en = 1; wr_addr = 6'd2; wr_data = 64'h1111_2222_3333_4444;
      step();
      wr_en = 0; wr_done = 1; rd_done = 1;
      step();
      wr_done = 0; rd_done = 0;
      chk("both_cnt", full_cnt, 2'd1);
      chk("both_wrdy", wr_ready, 1'b1);
      chk("both_rrdy", rd_ready, 1'b1);
      rd_en = 1; rd_addr = 6'd2;
      step();
      rd_en = 0;
      chk("both_rbank", rd_data, 64'h1111_2222_3333_4444);
      wr_done = 1;
      step();
      wr_done = 0;
      chk("both_wbank_cnt", full_cnt, 2'd2);
      chk("both_wbank_wrdy", wr_ready, 1'b0);

      // Synchronous clear overrides same-cycle strobes
      rst_sync = 1; rd_en = 1; rd_done = 1; wr_en = 1;
      step();
      idle();
      chk_reset_outs("sync");

      // Async reset in the middle of filling bank1
      wr_en = 1; wr_addr = 6'd0; wr_data = 64'h42;
      step();
      wr_en = 0; wr_done = 1;
      step();
      wr_done = 0;
      for (int a = 0; a < 4; a++) begin
         wr_en = 1; wr_addr = AW'(a); wr_data = 64'hBEEF;
         if (a == 3) begin rd_en = 1; rd_addr = 6'd0; end
         step();
      end
      rd_en = 0;
      chk("pre_arst_data", rd_data, 64'h42);
      chk("pre_arst_cnt", full_cnt, 2'd1);
      #2 rst_an = 0;
      #1;
      chk_reset_outs("arst");
      wr_en = 0;
      #1 rst_an = 1;
      rd_en = 1; rd_addr = 6'd0;
      step();
      rd_en = 0;
      chk("arst_rd_err", err, 1'b1);
      chk("arst_rd_valid", rd_valid, 1'b0);

      // Parity: flip one stored bit in bank0 addr 9
      wr_en = 1; wr_addr = 6'd9; wr_data = 64'h55;
      step();
      wr_addr = 6'd10; wr_data = 64'h77;
      step();
      wr_en = 0; wr_done = 1;
      step();
      wr_done = 0;
`ifdef SURV_BUF_PARITY_EN
      dut.g_bank[0].u_sram.mem[9][0] = ~dut.g_bank[0].u_sram.mem[9][0];
      rd_en = 1; rd_addr = 6'd9;
      step();
      chk("par_bad_valid", rd_valid, 1'b1);
      chk("par_bad", rd_perr, 1'b1);
      rd_addr = 6'd10;
      step();
      rd_en = 0;
      chk("par_good", rd_perr, 1'b0);
      chk("par_good_data", rd_data, 64'h77);
`else
      rd_en = 1; rd_addr = 6'd9;
      step();
      chk("nopar_data", rd_data, 64'h55);
      chk("nopar_perr", rd_perr, 1'b0);
      rd_en = 0;
`endif
      step();
      chk("par_idle_perr", rd_perr, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
